// File: rtl/alpu_sched_pkg.sv
// Shared types and helpers for the ALPU issue scheduler and its round-robin arbiter.
package alpu_sched_pkg;

  localparam int ALPU_INSTR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } sched_state_t;

  // Width of a requester id; a single requester still needs one bit to name it
  function automatic int reqIdWidth(input int numReq);
    return (numReq > 1) ? $clog2(numReq) : 1;
  endfunction

endpackage

// File: rtl/alpu_rr_arbiter.sv
// Stateless round-robin arbiter: picks the first valid requester at or after the
// pointer, wrapping around. The pointer register itself lives in the scheduler.
module alpu_rr_arbiter
  import alpu_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = reqIdWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  // Walk the requesters in priority order starting at the pointer; first hit wins
  always_comb begin
    int          cand;
    logic [ID_W-1:0] candIdx;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = 0;
    candIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      candIdx = ID_W'(cand);
      if (!any_o && valid_i[candIdx]) begin
        any_o            = 1'b1;
        grant_o[candIdx] = 1'b1;
        idx_o            = candIdx;
      end
    end
  end

endmodule

// File: rtl/alpu_issue_scheduler.sv
// Shares one ALPU between NUM_REQ requesters. A round-robin winner is accepted in
// IDLE, its operands are latched and held on the ALPU for ALPU_LATENCY+1 cycles,
// the result is captured and returned tagged with the requester id over a
// valid/ready port. One operation is in flight at a time.
// Optional per-requester saturating grant counters are built when the macro
// ALPU_SCHED_PERF_CNT_EN is defined; otherwise grant_cnt_o is tied to zero.
module alpu_issue_scheduler
  import alpu_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int REG_WIDTH    = 4,
  parameter int ALPU_LATENCY = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ*ALPU_INSTR_W-1:0]   req_instr_i,
  input  logic [NUM_REQ*REG_WIDTH-1:0]      req_a_i,
  input  logic [NUM_REQ*REG_WIDTH-1:0]      req_b_i,
  input  logic [NUM_REQ-1:0]                req_cin_i,
  output logic [ALPU_INSTR_W-1:0]           alpu_instr_o,
  output logic [REG_WIDTH-1:0]              alpu_a_o,
  output logic [REG_WIDTH-1:0]              alpu_b_o,
  output logic                              alpu_cin_o,
  input  logic [REG_WIDTH-1:0]              alpu_out_i,
  input  logic                              alpu_cout_i,
  output logic                              resp_valid_o,
  input  logic                              resp_ready_i,
  output logic [reqIdWidth(NUM_REQ)-1:0]    resp_id_o,
  output logic [REG_WIDTH-1:0]              resp_out_o,
  output logic                              resp_cout_o,
  output logic [NUM_REQ*CNT_WIDTH-1:0]      grant_cnt_o
);

  localparam int ID_W  = reqIdWidth(NUM_REQ);
  localparam int LAT_W = (ALPU_LATENCY > 0) ? $clog2(ALPU_LATENCY + 1) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ALPU_LATENCY);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  sched_state_t state_q, state_d;

  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic [LAT_W-1:0]        latCnt_q, latCnt_d;
  logic [ALPU_INSTR_W-1:0] instr_q, instr_d;
  logic [REG_WIDTH-1:0]    a_q, a_d;
  logic [REG_WIDTH-1:0]    b_q, b_d;
  logic                    cin_q, cin_d;
  logic [ID_W-1:0]         id_q, id_d;
  logic [REG_WIDTH-1:0]    res_q, res_d;
  logic                    resCout_q, resCout_d;

  logic [NUM_REQ-1:0] arbGrant;
  logic [ID_W-1:0]    arbIdx;
  logic               arbAny;
  logic               handshake;
  logic               execDone;

  alpu_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arbiter (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (arbGrant),
    .idx_o   (arbIdx),
    .any_o   (arbAny)
  );

  assign handshake = (state_q == IDLE) && arbAny;
  assign execDone  = (state_q == EXEC) && (latCnt_q == '0);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: accept, run the ALPU for its latency, then hold the response
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (handshake)    state_d = EXEC;
      EXEC:    if (execDone)     state_d = RESP;
      RESP:    if (resp_ready_i) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // FSM outputs: ready only in IDLE (and never while reset is held), valid only in RESP
  always_comb begin
    req_ready_o  = '0;
    resp_valid_o = 1'b0;
    if (!reset && (state_q == IDLE)) begin
      req_ready_o = arbGrant;
    end
    if (state_q == RESP) begin
      resp_valid_o = 1'b1;
    end
  end

  // Datapath next state: latch the winner on handshake, count down EXEC, capture the result
  always_comb begin
    ptr_d     = ptr_q;
    latCnt_d  = latCnt_q;
    instr_d   = instr_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    id_d      = id_q;
    res_d     = res_q;
    resCout_d = resCout_q;
    if (handshake) begin
      instr_d = '0;
      a_d     = '0;
      b_d     = '0;
      cin_d   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (arbGrant[i]) begin
          instr_d = req_instr_i[i*ALPU_INSTR_W +: ALPU_INSTR_W];
          a_d     = req_a_i[i*REG_WIDTH +: REG_WIDTH];
          b_d     = req_b_i[i*REG_WIDTH +: REG_WIDTH];
          cin_d   = req_cin_i[i];
        end
      end
      id_d     = arbIdx;
      latCnt_d = LAT_LOAD;
      ptr_d    = (arbIdx == LAST_ID) ? '0 : arbIdx + 1'b1;
    end
    if (state_q == EXEC) begin
      if (latCnt_q == '0) begin
        res_d     = alpu_out_i;
        resCout_d = alpu_cout_i;
      end else begin
        latCnt_d = latCnt_q - 1'b1;
      end
    end
  end

  // Datapath registers; an asynchronous reset discards any in-flight operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= '0;
      latCnt_q  <= '0;
      instr_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      id_q      <= '0;
      res_q     <= '0;
      resCout_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      latCnt_q  <= latCnt_d;
      instr_q   <= instr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      id_q      <= id_d;
      res_q     <= res_d;
      resCout_q <= resCout_d;
    end
  end

  assign alpu_instr_o = instr_q;
  assign alpu_a_o     = a_q;
  assign alpu_b_o     = b_q;
  assign alpu_cin_o   = cin_q;

  assign resp_id_o    = id_q;
  assign resp_out_o   = res_q;
  assign resp_cout_o  = resCout_q;

`ifdef ALPU_SCHED_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] grantCnt_q [NUM_REQ];

  // Per-requester grant counters that stick at all-ones instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        grantCnt_q[i] <= '0;
      end
    end else if (handshake) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (arbGrant[i] && (grantCnt_q[i] != '1)) begin
          grantCnt_q[i] <= grantCnt_q[i] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
    assign grant_cnt_o[g*CNT_WIDTH +: CNT_WIDTH] = grantCnt_q[g];
  end
`else
  assign grant_cnt_o = '0;
`endif

endmodule
